// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: default parameter
// values, channel count and channel index names.
package btn_pkg;

    localparam int BTN_N                   = 5;
    localparam int BTN_DEBOUNCE_CYCLES_DEF = 200000;
    localparam int BTN_REPEAT_DELAY_DEF    = 50000000;
    localparam int BTN_REPEAT_RATE_DEF     = 10000000;

    localparam int BTN_CENTER = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level
// and registered one-cycle press/release pulses.
// Optional auto-repeat when BTN_AUTOREPEAT_EN is defined: a held button
// produces extra press pulses after REPEAT_DELAY cycles, then every
// REPEAT_RATE cycles, until release.
// The release pulse is called "released" because "release" is a keyword.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = BTN_REPEAT_RATE_DEF
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic released
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          settle;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rep_cnt;
`endif

    // Synchronised input has disagreed with level long enough to be accepted.
    always_comb begin
        settle = (s2 != level) && (cnt == CNT_TERM);
    end

    // Synchroniser, stability counter, level and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            s1       <= raw;
            s2       <= s1;
            press    <= 1'b0;
            released <= 1'b0;

            if (s2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                cnt      <= '0;
                level    <= s2;
                press    <= s2;
                released <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end

`ifdef BTN_AUTOREPEAT_EN
            // Repeat timer starts on the accepted press; a pending release
            // takes priority so press and release never coincide.
            if (settle && s2) begin
                rep_cnt <= REP_FIRST;
            end else if (level && !settle) begin
                if (rep_cnt == '0) begin
                    press   <= 1'b1;
                    rep_cnt <= REP_NEXT;
                end else begin
                    rep_cnt <= rep_cnt - 1'b1;
                end
            end else begin
                rep_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: N independent debounce channels,
// each giving a clean level plus one-cycle press and release pulses.
// Define BTN_AUTOREPEAT_EN to turn a held button into a periodic press train.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N               = BTN_N,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = BTN_REPEAT_RATE_DEF
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] raw,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] released
);

    // One independent conditioner per button.
    for (genvar i = 0; i < N; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw[i]),
            .level    (level[i]),
            .press    (press[i]),
            .released (released[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios with literal
// latency/count expectations plus randomized stimulus against a window-based
// model of the debounce rule.
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int REP_HOLD_PRESSES = 8;
`else
    localparam int REP_HOLD_PRESSES = 1;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] released;

    int n_cmp = 0;
    int n_err = 0;
    int pcnt [N];
    int rcnt [N];

    btn_conditioner #(
        .N               (N),
        .DEBOUNCE_CYCLES (DB)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw      (raw),
        .level    (level),
        .press    (press),
        .released (released)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: raw samples since reset; a channel flips when the synchronised
    // value (raw two edges earlier) has opposed the level for DB samples.
    logic [N-1:0] hist [$];
    logic [N-1:0] mlvl, exp_level, exp_press, exp_rel;
    int           t0 [N];

    always @(posedge clk) begin
        if (!rst) begin
            hist.delete();
            mlvl      = '0;
            exp_level = '0;
            exp_press = '0;
            exp_rel   = '0;
            for (int c = 0; c < N; c++) t0[c] = 0;
        end else begin
            int e;
            hist.push_back(raw);
            e = hist.size() - 1;
            for (int c = 0; c < N; c++) begin
                bit flip;
                flip = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    int idx;
                    logic [N-1:0] smp;
                    idx = e - 2 - j;
                    smp = (idx >= 0) ? hist[idx] : '0;
                    if (smp[c] == mlvl[c]) flip = 1'b0;
                end
                exp_press[c] = 1'b0;
                exp_rel[c]   = 1'b0;
                if (flip) begin
                    mlvl[c] = ~mlvl[c];
                    if (mlvl[c]) begin
                        exp_press[c] = 1'b1;
                        t0[c] = e;
                    end else begin
                        exp_rel[c] = 1'b1;
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (mlvl[c]) begin
                    int k;
                    k = e - t0[c];
                    if (k >= RD && ((k - RD) % RR) == 0) exp_press[c] = 1'b1;
                end
`endif
            end
            exp_level = mlvl;
        end
    end

    // Every-cycle comparison of all outputs, plus pulse counters.
    always @(negedge clk) begin
        logic [N-1:0] el, ep, er;
        el = rst ? exp_level : '0;
        ep = rst ? exp_press : '0;
        er = rst ? exp_rel   : '0;
        n_cmp++;
        if (level !== el || press !== ep || released !== er) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t: level/press/release got %b/%b/%b expected %b/%b/%b",
                     $time, level, press, released, el, ep, er);
        end
        for (int c = 0; c < N; c++) begin
            if (press[c] === 1'b1)    pcnt[c]++;
            if (released[c] === 1'b1) rcnt[c]++;
        end
    end

    task automatic check_eq(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count edges until a pulse appears on a channel; -1 if it never does.
    task automatic measure(input int ch, input bit want_press, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if ((want_press ? press[ch] : released[ch]) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int p_snap [N];
        int r_snap [N];
        int others;

        for (int c = 0; c < N; c++) begin
            pcnt[c] = 0;
            rcnt[c] = 0;
        end
        rst = 1'b0;
        raw = '0;
        tick(3);
        check_eq("reset_level", int'(level), 0);
        check_eq("reset_press", int'(press), 0);
        rst = 1'b1;
        tick(4);

        // Clean press and release on channel 0.
        for (int c = 0; c < N; c++) begin p_snap[c] = pcnt[c]; r_snap[c] = rcnt[c]; end
        raw[0] = 1'b1;
        measure(0, 1'b1, lat);
        check_eq("clean_press_latency", lat, 6);
        check_eq("clean_level_high", int'(level[0]), 1);
        tick(20 - 6);
        raw[0] = 1'b0;
        measure(0, 1'b0, lat);
        check_eq("clean_release_latency", lat, 6);
        tick(4);
        check_eq("clean_press_count", pcnt[0] - p_snap[0], 1);
        check_eq("clean_release_count", rcnt[0] - r_snap[0], 1);
        others = 0;
        for (int c = 1; c < N; c++) others += (pcnt[c] - p_snap[c]) + (rcnt[c] - r_snap[c]);
        check_eq("clean_other_channels", others, 0);

        // Glitch shorter than the debounce window on channel 1.
        p_snap[1] = pcnt[1];
        r_snap[1] = rcnt[1];
        raw[1] = 1'b1;
        tick(3);
        raw[1] = 1'b0;
        tick(12);
        check_eq("glitch_press_count", pcnt[1] - p_snap[1], 0);
        check_eq("glitch_release_count", rcnt[1] - r_snap[1], 0);

        // Bouncing press on channel 2.
        p_snap[2] = pcnt[2];
        for (int k = 0; k < 4; k++) begin
            raw[2] = (k % 2 == 0);
            tick(2);
        end
        raw[2] = 1'b1;
        measure(2, 1'b1, lat);
        check_eq("bounce_press_latency", lat, 6);
        tick(10);
        check_eq("bounce_press_count", pcnt[2] - p_snap[2], 1);
        raw[2] = 1'b0;
        tick(10);

        // Simultaneous press on channels 4 and 3.
        raw[4] = 1'b1;
        raw[3] = 1'b1;
        measure(4, 1'b1, lat);
        check_eq("simul_press_latency", lat, 6);
        check_eq("simul_press3_same_cycle", int'(press[3]), 1);
        raw[4] = 1'b0;
        raw[3] = 1'b0;
        tick(10);

        // Reset in the middle of a count.
        p_snap[0] = pcnt[0];
        raw[0] = 1'b1;
        tick(3);
        rst = 1'b0;
        #1;
        check_eq("midreset_level", int'(level), 0);
        check_eq("midreset_press", int'(press), 0);
        tick(3);
        check_eq("midreset_no_pulse", pcnt[0] - p_snap[0], 0);
        rst = 1'b1;
        measure(0, 1'b1, lat);
        check_eq("postreset_press_latency", lat, 6);
        raw[0] = 1'b0;
        tick(10);

        // Held button on channel 3: repeats only in auto-repeat builds.
        p_snap[3] = pcnt[3];
        r_snap[3] = rcnt[3];
        raw[3] = 1'b1;
        tick(30);
        raw[3] = 1'b0;
        tick(12);
        check_eq("hold_press_count", pcnt[3] - p_snap[3], REP_HOLD_PRESSES);
        check_eq("hold_release_count", rcnt[3] - r_snap[3], 1);

        // Randomized bouncing on all channels with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                tick(2);
                rst = 1'b1;
            end
            tick(1);
        end
        raw = '0;
        tick(20);
        check_eq("final_level_idle", int'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel push-button conditioner sitting directly upstream of the shifter/LFSR display top: synchronises raw board buttons, debounces each channel, and emits a clean level plus single-cycle press and release pulses. Downstream logic consumes `release`/`press` pulses instead of doing its own `btn_r & ~btn` edge detection, and can drive the LFSR step from a clean `next` pulse rather than a raw button. An optional auto-repeat turns a held button into a periodic press train.

## Interface
- `N` — 5 — channel count; bit 4 = center (`next`), bits 3..0 = up, down, left, right.
- `DEBOUNCE_CYCLES` — 200000 — consecutive stable cycles required to accept a change; legal range ≥ 2.
- `REPEAT_DELAY` — 50000000 — cycles from first press pulse to first repeat pulse (auto-repeat builds only).
- `REPEAT_RATE` — 10000000 — cycles between subsequent repeat pulses (auto-repeat builds only); ≥ 1.

- `clk` in 1 — single clock; all state on posedge.
- `rst` in 1 — asynchronous, active-low reset (asserted when 0).
- `raw` in N — unsynchronised button inputs, active-high (1 = pressed).
- `level` out N — debounced button state.
- `press` out N — one-cycle pulse on debounced 0→1 (plus repeats if enabled).
- `release` out N — one-cycle pulse on debounced 1→0.

## Operation
- Per channel: 2-FF synchroniser (`s1`, `s2`) → stability counter → `level` register → pulse registers. Channels fully independent.
- Counter rule each cycle: if `s2 == level`, counter ← 0. Else if counter == DEBOUNCE_CYCLES−1: `level` ← `s2`, counter ← 0, pulse `press` (new level 1) or `release` (new level 0). Else counter ← counter+1.
- Counter width `$clog2(DEBOUNCE_CYCLES)`; never wraps (cleared at terminal value).
- Any input disagreement lasting fewer than DEBOUNCE_CYCLES consecutive cycles at `s2` produces no output change; bounce restarts the count from 0.
- `press` and `release` never both high on one channel in the same cycle; every `release` is preceded by a `press` since the last reset.
- Simultaneous events on different channels: each pulses in its own timing, same cycle permitted.

## Timing
- Reset (rst = 0, async): `s1`, `s2`, counters, `level`, `press`, `release`, repeat state all 0 immediately; no pulses while asserted.
- After reset deassertion with `raw` held high: normal debounce → one `press` pulse; no spurious `release`.
- Latency: `raw` changes before edge k and stays stable → `s2` updated at edge k+1 → `level` and pulse registered at edge k+DEBOUNCE_CYCLES+1; observable DEBOUNCE_CYCLES+2 edges after the change.
- Pulses are exactly one cycle wide, registered outputs, coincident with the `level` change.
- Reset mid-count: count discarded; no pulse generated for the interrupted transition.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: per-channel repeat counter runs while `level` = 1. Extra `press` pulses at REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_RATE cycles until release; repeat counter clears on release or reset; `release` unaffected.
- Undefined: exactly one `press` per debounced press; repeat logic and parameters unused; REPEAT_* not range-checked.

## Structure
- Package `btn_pkg`: default parameter values, N default, channel index constants (`BTN_CENTER`=4, `BTN_UP`=3, `BTN_DOWN`=2, `BTN_LEFT`=1, `BTN_RIGHT`=0).
- Sub-module `btn_debounce_ch`: one channel (synchroniser, counter, level, pulses, optional repeat); `btn_conditioner` instantiates N copies via generate.

## Test plan
Bench parameters: N=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Clean press: raw[0] 0→1, held 20 cycles, then 0 → `level[0]` rises and single `press[0]` pulse 6 edges after rise; single `release[0]` 6 edges after fall; no other channel activity.
- Glitch: raw[1] high for 3 cycles → no `level`, `press` or `release` change.
- Bounce: raw[2] toggles 1,0,1,0,1 every 2 cycles then stays 1 → exactly one `press[2]`, 6 edges after the final rise.
- Simultaneous: raw[4] and raw[3] rise together → `press[4]` and `press[3]` in the same cycle; N channels don't interfere.
- Reset mid-count: raw[0] rises, rst pulled low after 3 cycles → all outputs 0 at once, no pulse; after rst high with raw[0]=1 → `press[0]` 6 edges later.
- Auto-repeat (`BTN_AUTOREPEAT_EN`): raw[3] held 30 cycles → `press[3]` at edge t, t+10, t+13, t+16, … until release; without macro only at t.
